// File: rtl/bounce_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_controller
//  Description : Game-logic side of the ball bounce interface. Detects wall,
//                paddle and miss conditions from ball/paddle positions, drives
//                bounce_trigger/bounce_direction to the ball, serves the ball,
//                keeps score and resets the ball after each point.
//                Optional feature macro: PONG_AUTO_SERVE_EN (idle auto serve).
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_controller #(
`ifdef PONG_AUTO_SERVE_EN
    parameter int AUTO_SERVE_TICKS = 180,
`endif
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_SIZE      = 30,
    parameter int PADDLE_W       = 10,
    parameter int PADDLE_H       = 80,
    parameter int PADDLE_L_X     = 20,
    parameter int PADDLE_R_X     = 610,
    parameter int COOLDOWN_TICKS = 8,
    parameter int POINT_TICKS    = 60,
    parameter int WIN_SCORE      = 9
) (
    input  logic       tick,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    input  logic       serve,
    output logic       bounce_trigger,
    output logic       bounce_direction,
    output logic       ball_reset_n,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    // Direction encoding: wall hit flips up/down, paddle hit flips left/right
    localparam logic HORIZONTAL = 1'b0;
    localparam logic VERTICAL   = 1'b1;

    localparam logic [10:0] c_ball_size  = 11'(BALL_SIZE);
    localparam logic [10:0] c_screen_w   = 11'(SCREEN_W);
    localparam logic [10:0] c_screen_h   = 11'(SCREEN_H);
    localparam logic [10:0] c_pad_h      = 11'(PADDLE_H);
    localparam logic [10:0] c_pad_l_face = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] c_pad_r_x    = 11'(PADDLE_R_X);
    localparam logic [7:0]  c_cool_load  = 8'(COOLDOWN_TICKS - 1);
    localparam logic [7:0]  c_point_load = 8'(POINT_TICKS - 1);
    localparam logic [3:0]  c_win        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_SERVE_WAIT = 3'd0,
        S_LAUNCH     = 3'd1,
        S_PLAY       = 3'd2,
        S_HOLD       = 3'd3,
        S_COOLDOWN   = 3'd4,
        S_POINT      = 3'd5,
        S_GAME_OVER  = 3'd6
    } state_t;

    state_t      r_state, w_next_state;
    logic        r_dir, w_next_dir;
    logic        r_last_dir, w_next_last_dir;
    logic [19:0] r_latch, w_next_latch;
    logic [7:0]  r_timer, w_next_timer;
    logic [3:0]  r_score_l, w_next_score_l;
    logic [3:0]  r_score_r, w_next_score_r;
    logic        r_serve_dir, w_next_serve_dir;
    logic        r_trigger, r_ball_reset_n, r_game_over;

    // Geometry is evaluated on 11-bit sums so edge arithmetic never wraps
    logic [10:0] w_bx, w_by, w_bx_end, w_by_end, w_pl_end, w_pr_end;
    logic        w_wall_hit, w_pad_l, w_pad_r, w_pad_hit, w_miss_l, w_miss_r;
    logic        w_moved, w_serve_go;
    logic [3:0]  w_score_l_inc, w_score_r_inc;

    assign w_bx     = {1'b0, ball_x};
    assign w_by     = {1'b0, ball_y};
    assign w_bx_end = w_bx + c_ball_size;
    assign w_by_end = w_by + c_ball_size;
    assign w_pl_end = {1'b0, paddle_l_y} + c_pad_h;
    assign w_pr_end = {1'b0, paddle_r_y} + c_pad_h;

    assign w_wall_hit = (ball_y == 10'd0) || (w_by_end >= c_screen_h);
    assign w_pad_l    = (w_bx <= c_pad_l_face) && (w_by_end > {1'b0, paddle_l_y}) && (w_by < w_pl_end);
    assign w_pad_r    = (w_bx_end >= c_pad_r_x) && (w_by_end > {1'b0, paddle_r_y}) && (w_by < w_pr_end);
    assign w_pad_hit  = w_pad_l || w_pad_r;
    assign w_miss_l   = (ball_x == 10'd0);
    assign w_miss_r   = (w_bx_end >= c_screen_w);
    assign w_moved    = ({ball_x, ball_y} != r_latch);

    // Scores saturate at the winning score
    assign w_score_l_inc = (r_score_l < c_win) ? r_score_l + 4'd1 : r_score_l;
    assign w_score_r_inc = (r_score_r < c_win) ? r_score_r + 4'd1 : r_score_r;

`ifdef PONG_AUTO_SERVE_EN
    logic [9:0] r_idle;

    assign w_serve_go = serve || (r_idle == 10'(AUTO_SERVE_TICKS));

    // Idle counter runs only while waiting to serve with serve low
    always_ff @(posedge tick) begin
        if (reset || (r_state != S_SERVE_WAIT) || w_serve_go) begin
            r_idle <= 10'd0;
        end else begin
            r_idle <= r_idle + 10'd1;
        end
    end
`else
    assign w_serve_go = serve;
`endif

    // Next-state logic; miss outranks paddle, paddle outranks wall
    always_comb begin
        w_next_state     = r_state;
        w_next_dir       = r_dir;
        w_next_last_dir  = r_last_dir;
        w_next_latch     = r_latch;
        w_next_timer     = r_timer;
        w_next_score_l   = r_score_l;
        w_next_score_r   = r_score_r;
        w_next_serve_dir = r_serve_dir;
        case (r_state)
            S_SERVE_WAIT: begin
                if (w_serve_go) begin
                    w_next_state = S_LAUNCH;
                    w_next_dir   = r_serve_dir;
                    w_next_latch = {ball_x, ball_y};
                end
            end
            S_LAUNCH: begin
                if (w_moved) begin
                    w_next_state = S_PLAY;
                end
            end
            S_PLAY, S_COOLDOWN: begin
                if (w_miss_l || w_miss_r) begin
                    if (w_miss_l) begin
                        w_next_score_r = w_score_r_inc;
                    end else begin
                        w_next_score_l = w_score_l_inc;
                    end
                    w_next_state     = S_POINT;
                    w_next_timer     = c_point_load;
                    w_next_serve_dir = ~r_serve_dir;
                end else if (w_pad_hit && !(r_state == S_COOLDOWN && r_last_dir == VERTICAL)) begin
                    w_next_state = S_HOLD;
                    w_next_dir   = VERTICAL;
                    w_next_latch = {ball_x, ball_y};
                end else if (w_wall_hit && !(r_state == S_COOLDOWN && r_last_dir == HORIZONTAL)) begin
                    w_next_state = S_HOLD;
                    w_next_dir   = HORIZONTAL;
                    w_next_latch = {ball_x, ball_y};
                end else if (r_state == S_COOLDOWN) begin
                    if (r_timer == 8'd0) begin
                        w_next_state = S_PLAY;
                    end else begin
                        w_next_timer = r_timer - 8'd1;
                    end
                end
            end
            S_HOLD: begin
                if (w_moved) begin
                    w_next_state    = S_COOLDOWN;
                    w_next_last_dir = r_dir;
                    w_next_timer    = c_cool_load;
                end
            end
            S_POINT: begin
                if (r_timer == 8'd0) begin
                    w_next_state = ((r_score_l == c_win) || (r_score_r == c_win)) ? S_GAME_OVER : S_SERVE_WAIT;
                end else begin
                    w_next_timer = r_timer - 8'd1;
                end
            end
            S_GAME_OVER: begin
                w_next_state = S_GAME_OVER;
            end
            default: begin
                w_next_state = S_SERVE_WAIT;
            end
        endcase
    end

    // State and registered outputs; outputs follow the state being entered
    always_ff @(posedge tick) begin
        if (reset) begin
            r_state        <= S_SERVE_WAIT;
            r_dir          <= HORIZONTAL;
            r_last_dir     <= HORIZONTAL;
            r_latch        <= 20'd0;
            r_timer        <= 8'd0;
            r_score_l      <= 4'd0;
            r_score_r      <= 4'd0;
            r_serve_dir    <= VERTICAL;
            r_trigger      <= 1'b0;
            r_ball_reset_n <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_dir          <= w_next_dir;
            r_last_dir     <= w_next_last_dir;
            r_latch        <= w_next_latch;
            r_timer        <= w_next_timer;
            r_score_l      <= w_next_score_l;
            r_score_r      <= w_next_score_r;
            r_serve_dir    <= w_next_serve_dir;
            r_trigger      <= (w_next_state == S_LAUNCH) || (w_next_state == S_HOLD);
            r_ball_reset_n <= (w_next_state != S_POINT) && (w_next_state != S_GAME_OVER);
            r_game_over    <= (w_next_state == S_GAME_OVER);
        end
    end

    assign bounce_trigger   = r_trigger;
    assign bounce_direction = r_dir;
    assign ball_reset_n     = r_ball_reset_n;
    assign score_l          = r_score_l;
    assign score_r          = r_score_r;
    assign game_over        = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_bounce_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_controller
//  Description : Self-checking bench for bounce_controller. Vectors of
//                {inputs, expected outputs} are queued as stimulus is driven
//                and compared one tick later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_controller;

    logic       tick = 1'b0;
    logic       reset;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic       serve;
    logic       bounce_trigger, bounce_direction, ball_reset_n, game_over;
    logic [3:0] score_l, score_r;

    always #5 tick = ~tick;

    bounce_controller dut (
        .tick             (tick),
        .reset            (reset),
        .ball_x           (ball_x),
        .ball_y           (ball_y),
        .paddle_l_y       (paddle_l_y),
        .paddle_r_y       (paddle_r_y),
        .serve            (serve),
        .bounce_trigger   (bounce_trigger),
        .bounce_direction (bounce_direction),
        .ball_reset_n     (ball_reset_n),
        .score_l          (score_l),
        .score_r          (score_r),
        .game_over        (game_over)
    );

    typedef struct {
        logic       rst;
        logic [9:0] bx, by, pl, pr;
        logic       sv;
        logic       trig, dir, rstn;
        logic [3:0] sl, sr;
        logic       go;
    } vec_t;

    vec_t table_q[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;
    logic m_dir, m_sd;

    function automatic vec_t mk(input int rst, input int bx, input int by, input int pl, input int pr,
                                input int sv, input int trig, input int dir, input int rstn,
                                input int sl, input int sr, input int go);
        vec_t v;
        v.rst  = 1'(rst);
        v.bx   = 10'(bx);
        v.by   = 10'(by);
        v.pl   = 10'(pl);
        v.pr   = 10'(pr);
        v.sv   = 1'(sv);
        v.trig = 1'(trig);
        v.dir  = 1'(dir);
        v.rstn = 1'(rstn);
        v.sl   = 4'(sl);
        v.sr   = 4'(sr);
        v.go   = 1'(go);
        return v;
    endfunction

    task automatic row(input int rst, input int bx, input int by, input int pl, input int sv,
                       input int trig, input int dir, input int rstn, input int sr, input int n);
        for (int i = 0; i < n; i++) begin
            table_q.push_back(mk(rst, bx, by, pl, 400, sv, trig, dir, rstn, 0, sr, 0));
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", name, step_no, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, compare once the DUT has responded
    task automatic step(input vec_t v);
        vec_t e;
        reset      = v.rst;
        ball_x     = v.bx;
        ball_y     = v.by;
        paddle_l_y = v.pl;
        paddle_r_y = v.pr;
        serve      = v.sv;
        sb_q.push_back(v);
        @(posedge tick);
        #1;
        e = sb_q.pop_front();
        chk("bounce_trigger", {3'b0, bounce_trigger}, {3'b0, e.trig});
        chk("bounce_direction", {3'b0, bounce_direction}, {3'b0, e.dir});
        chk("ball_reset_n", {3'b0, ball_reset_n}, {3'b0, e.rstn});
        chk("score_l", score_l, e.sl);
        chk("score_r", score_r, e.sr);
        chk("game_over", {3'b0, game_over}, {3'b0, e.go});
        step_no++;
    endtask

    initial begin
        // reset, serve, wall bounce held while static
        row(1, 305, 225, 400, 0, 0, 0, 0, 0, 2);
        row(0, 305, 225, 400, 0, 0, 0, 1, 0, 1);
        row(0, 305, 225, 400, 1, 1, 1, 1, 0, 1);
        row(0, 305, 225, 400, 0, 1, 1, 1, 0, 1);
        row(0, 306, 226, 400, 0, 0, 1, 1, 0, 1);
        row(0, 300,   0, 400, 0, 1, 0, 1, 0, 6);
        row(0, 301,   1, 400, 0, 0, 0, 1, 0, 1);
        row(0, 305, 225, 400, 0, 0, 0, 1, 0, 8);
        // paddle hit, same-direction lockout for the cooldown, then retrigger
        row(0,  30, 220, 200, 0, 1, 1, 1, 0, 1);
        row(0,  29, 221, 200, 0, 0, 1, 1, 0, 9);
        row(0,  29, 221, 200, 0, 1, 1, 1, 0, 1);
        row(0, 305, 225, 400, 0, 0, 1, 1, 0, 9);
        // corner: paddle first, wall immediately after release
        row(0,  30,   0,   0, 0, 1, 1, 1, 0, 1);
        row(0,  31,   0,   0, 0, 0, 1, 1, 0, 1);
        row(0,  31,   0,   0, 0, 1, 0, 1, 0, 1);
        row(0,  32,   1,   0, 0, 0, 0, 1, 0, 1);
        row(0, 305, 225, 400, 0, 0, 0, 1, 0, 8);
        // left miss: point, ball held in reset, serve direction toggled
        row(0,   0, 225, 400, 0, 0, 0, 0, 1, 1);
        row(0, 305, 225, 400, 0, 0, 0, 0, 1, 59);
        row(0, 305, 225, 400, 0, 0, 0, 1, 1, 1);
        row(0, 305, 225, 400, 1, 1, 0, 1, 1, 1);
        row(0, 306, 226, 400, 0, 0, 0, 1, 1, 1);

        foreach (table_q[i]) begin
            step(table_q[i]);
        end

        // right misses until the left player wins
        m_dir = 1'b0;
        m_sd  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step(mk(0, 610, 225, 400, 400, 0, 0, m_dir, 0, k, 1, 0));
            m_sd = ~m_sd;
            for (int j = 0; j < 59; j++) begin
                step(mk(0, 305, 225, 400, 400, 0, 0, m_dir, 0, k, 1, 0));
            end
            if (k < 9) begin
                step(mk(0, 305, 225, 400, 400, 0, 0, m_dir, 1, k, 1, 0));
                step(mk(0, 305, 225, 400, 400, 1, 1, m_sd, 1, k, 1, 0));
                m_dir = m_sd;
                step(mk(0, 306, 226, 400, 400, 0, 0, m_dir, 1, k, 1, 0));
            end else begin
                step(mk(0, 305, 225, 400, 400, 0, 0, m_dir, 0, 9, 1, 1));
            end
        end
        // game over ignores serve and misses; only reset clears it
        step(mk(0, 305, 225, 400, 400, 1, 0, m_dir, 0, 9, 1, 1));
        step(mk(0,   0, 225, 400, 400, 1, 0, m_dir, 0, 9, 1, 1));
        step(mk(1, 305, 225, 400, 400, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 305, 225, 400, 400, 0, 0, 0, 1, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
